// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Classifies the debounced, active-low key level into single-cycle user events
// for the camera/display control logic: press, release, short click, double
// click, long press and auto-repeat while a long press is held.
//
// Ports:
//   sysclk        in   system clock, rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   key_in        in   debounced key level, 1 = released, 0 = pressed
//   key_held      out  registered level, 1 while the key is pressed
//   press_pulse   out  one-cycle pulse on a press (falling edge of key_in)
//   release_pulse out  one-cycle pulse on a release (rising edge of key_in)
//   short_click   out  one-cycle pulse when a lone click's window expires
//   double_click  out  one-cycle pulse on a second press inside the window
//   long_press    out  one-cycle pulse when a hold reaches LONG_MS
//   repeat_pulse  out  one-cycle pulse every REPEAT_MS after long_press
//
// All outputs are registered and appear one clock after the key level that
// causes them is first sampled.
// -----------------------------------------------------------------------------
module key_event_decoder #(
  parameter int unsigned CLK_CYC   = 10,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned CYC_PER_MS = 1_000_000 / CLK_CYC;
  localparam logic [31:0] LONG_END   = 32'(LONG_MS * CYC_PER_MS);
  localparam logic [31:0] DCLICK_END = 32'(DCLICK_MS * CYC_PER_MS);
  localparam logic [31:0] REPEAT_END = 32'(REPEAT_MS * CYC_PER_MS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] cnt_r;
  logic        key_d_r;
  logic        fall_s;
  logic        rise_s;

  // Edge detection against the previously sampled key level.
  always_comb begin
    fall_s = key_d_r & ~key_in;
    rise_s = ~key_d_r & key_in;
  end

  // Event FSM with the shared timer and all registered outputs.
  // key_d_r resets to 1 (released) so a key held through reset is seen as a
  // fresh press on the first edge after reset release.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= 32'd0;
      key_d_r       <= 1'b1;
      key_held      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      key_d_r       <= key_in;
      key_held      <= ~key_in;
      press_pulse   <= fall_s;
      release_pulse <= rise_s;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state_r)
        // Timer is unused while idle; keep it parked at zero.
        IDLE: begin
          cnt_r <= 32'd0;
          if (fall_s) begin
            state_r <= PRESS1;
          end else begin
            state_r <= IDLE;
          end
        end

        // A release on the threshold cycle takes priority over long_press.
        PRESS1: begin
          if (rise_s) begin
            state_r <= WAIT2;
            cnt_r   <= 32'd0;
          end else if (cnt_r == LONG_END - 32'd1) begin
            long_press <= 1'b1;
            state_r    <= LONG;
            cnt_r      <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end

        // A second press on the timeout cycle takes priority over short_click.
        WAIT2: begin
          if (fall_s) begin
            double_click <= 1'b1;
            state_r      <= PRESS2;
            cnt_r        <= 32'd0;
          end else if (cnt_r == DCLICK_END - 32'd1) begin
            short_click <= 1'b1;
            state_r     <= IDLE;
            cnt_r       <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end

        // Second press of a double click: no timed events, just wait for release.
        PRESS2: begin
          cnt_r <= 32'd0;
          if (rise_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= PRESS2;
          end
        end

        // Auto-repeat; the timer restarts after every repeat_pulse.
        LONG: begin
          if (rise_s) begin
            state_r <= IDLE;
            cnt_r   <= 32'd0;
          end else if (cnt_r == REPEAT_END - 32'd1) begin
            repeat_pulse <= 1'b1;
            cnt_r        <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for key_event_decoder with scaled-down timing
// (1 ms == 1 cycle): LONG_END = 20, DCLICK_END = 10, REPEAT_END = 5.
// Output vector order: {key_held, press, release, short, double, long, repeat}.
// -----------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int LONG_END   = 20;
  localparam int DCLICK_END = 10;
  localparam int REPEAT_END = 5;

  logic sysclk;
  logic sys_rst_n;
  logic key_in;
  logic key_held, press_pulse, release_pulse, short_click;
  logic double_click, long_press, repeat_pulse;
  logic [6:0] outs;

  int n_checks;
  int n_pass;

  key_event_decoder #(
    .CLK_CYC   (1_000_000),
    .LONG_MS   (20),
    .DCLICK_MS (10),
    .REPEAT_MS (5)
  ) dut (
    .sysclk        (sysclk),
    .sys_rst_n     (sys_rst_n),
    .key_in        (key_in),
    .key_held      (key_held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_click   (short_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse)
  );

  assign outs = {key_held, press_pulse, release_pulse, short_click,
                 double_click, long_press, repeat_pulse};

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------------------------------------------------------------------
  // Reference model: press/release timestamps and the click rules.
  // ---------------------------------------------------------------------------
  int   m_t;
  logic m_prev;
  int   m_lp;
  int   m_lr;
  bit   m_lr_valid;
  bit   m_first;
  bit   m_clickable;

  task automatic model_reset();
    m_t         = 0;
    m_prev      = 1'b1;
    m_lp        = 0;
    m_lr        = 0;
    m_lr_valid  = 1'b0;
    m_first     = 1'b0;
    m_clickable = 1'b0;
  endtask

  task automatic model_step(input logic k, output logic [6:0] e);
    logic fall, rise, sht, dbl, lng, rpt;
    m_t  = m_t + 1;
    fall = m_prev & ~k;
    rise = ~m_prev & k;
    sht  = 1'b0;
    dbl  = 1'b0;
    lng  = 1'b0;
    rpt  = 1'b0;
    if (fall) begin
      dbl        = m_lr_valid && m_clickable && (m_t - m_lr <= DCLICK_END);
      m_first    = !dbl;
      m_lp       = m_t;
      m_lr_valid = 1'b0;
    end
    if (!k && m_first) begin
      if (m_t - m_lp == LONG_END)
        lng = 1'b1;
      else if (m_t - m_lp > LONG_END && ((m_t - m_lp - LONG_END) % REPEAT_END) == 0)
        rpt = 1'b1;
    end
    if (rise) begin
      m_clickable = m_first && (m_t - m_lp <= LONG_END);
      m_lr        = m_t;
      m_lr_valid  = 1'b1;
    end
    if (k && !rise && m_lr_valid && m_clickable && (m_t - m_lr == DCLICK_END))
      sht = 1'b1;
    e      = {~k, fall, rise, sht, dbl, lng, rpt};
    m_prev = k;
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %b expected %b (hld,prs,rel,sht,dbl,lng,rpt) at %0t",
               name, got, exp, $time);
    end
  endtask

  // Drive one key sample, let the DUT clock it, and advance the model.
  task automatic step(input logic k, output logic [6:0] mexp);
    key_in = k;
    @(posedge sysclk);
    #1;
    model_step(k, mexp);
  endtask

  task automatic idle(input int n);
    logic [6:0] mv;
    for (int i = 0; i < n; i++) step(1'b1, mv);
  endtask

  // Asynchronous reset assertion; reset released mid-cycle.
  task automatic do_reset(input string name);
    sys_rst_n = 1'b0;
    #1;
    cmp(name, outs, 7'b0000000);
    @(posedge sysclk);
    @(posedge sysclk);
    #1;
    cmp(name, outs, 7'b0000000);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       key;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[17];
  logic [6:0] mv;
  logic [6:0] ev;
  logic       k;
  int         plen, rlen, sel;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    key_in    = 1'b1;
    sys_rst_n = 1'b1;
    model_reset();

    // Short click: 5 cycles pressed, then released.
    for (int i = 0; i < 17; i++) begin
      tbl[i].key = (i < 5) ? 1'b0 : 1'b1;
      tbl[i].exp = 7'b0000000;
    end
    tbl[0].exp  = 7'b1100000;
    tbl[1].exp  = 7'b1000000;
    tbl[2].exp  = 7'b1000000;
    tbl[3].exp  = 7'b1000000;
    tbl[4].exp  = 7'b1000000;
    tbl[5].exp  = 7'b0010000;
    tbl[15].exp = 7'b0001000;

    // Reset state
    #2;
    do_reset("reset_state");
    idle(3);
    cmp("idle_after_reset", outs, 7'b0000000);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].key, mv);
      cmp("short_click_tbl", outs, tbl[i].exp);
    end
    idle(12);

    // Long hold: 32 cycles low.
    for (int i = 0; i < 38; i++) begin
      k = (i < 32) ? 1'b0 : 1'b1;
      step(k, mv);
      ev = {~k, (i == 0), (i == 32), 1'b0, 1'b0, (i == 20), (i == 25 || i == 30)};
      cmp("long_hold", outs, ev);
    end
    idle(12);

    // Double click: press 3, release 4, press 3.
    for (int i = 0; i < 25; i++) begin
      k = (i < 3 || (i >= 7 && i < 10)) ? 1'b0 : 1'b1;
      step(k, mv);
      ev = {~k, (i == 0 || i == 7), (i == 3 || i == 10), 1'b0, (i == 7), 1'b0, 1'b0};
      cmp("double_click", outs, ev);
    end
    idle(12);

    // Second press in the WAIT2 timeout cycle.
    for (int i = 0; i < 30; i++) begin
      k = (i < 2 || (i >= 12 && i < 14)) ? 1'b0 : 1'b1;
      step(k, mv);
      ev = {~k, (i == 0 || i == 12), (i == 2 || i == 14), 1'b0, (i == 12), 1'b0, 1'b0};
      cmp("race_wait2_timeout", outs, ev);
    end
    idle(12);

    // Release in the PRESS1 threshold cycle.
    for (int i = 0; i < 33; i++) begin
      k = (i < 20) ? 1'b0 : 1'b1;
      step(k, mv);
      ev = {~k, (i == 0), (i == 20), (i == 30), 1'b0, 1'b0, 1'b0};
      cmp("race_press1_threshold", outs, ev);
    end
    idle(12);

    // Reset mid-LONG with the key held through reset.
    for (int i = 0; i < 22; i++) begin
      step(1'b0, mv);
      ev = {1'b1, (i == 0), 1'b0, 1'b0, 1'b0, (i == 20), 1'b0};
      cmp("pre_reset_long", outs, ev);
    end
    do_reset("reset_mid_long");
    for (int i = 0; i < 35; i++) begin
      k = (i < 22) ? 1'b0 : 1'b1;
      step(k, mv);
      ev = {~k, (i == 0), (i == 22), 1'b0, 1'b0, (i == 20), 1'b0};
      cmp("post_reset_long", outs, ev);
    end
    idle(12);

    // Randomized runs against the reference model, biased toward boundaries.
    for (int r = 0; r < 80; r++) begin
      sel  = $urandom_range(0, 3);
      plen = (sel == 0) ? $urandom_range(19, 21) : $urandom_range(1, 40);
      sel  = $urandom_range(0, 3);
      rlen = (sel == 0) ? $urandom_range(9, 11) : $urandom_range(1, 16);
      for (int j = 0; j < plen; j++) begin
        step(1'b0, mv);
        cmp("random_model", outs, mv);
      end
      for (int j = 0; j < rlen; j++) begin
        step(1'b1, mv);
        cmp("random_model", outs, mv);
      end
      if (r % 25 == 24) do_reset("random_reset");
    end
    for (int j = 0; j < 15; j++) begin
      step(1'b1, mv);
      cmp("random_tail", outs, mv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
